// File: rtl/alu4_seq.sv
// alu4_seq: valid/ready command sequencer for an external alu4, with optional shift-add multiply
// Define ALU4_SEQ_MUL_EN to build the multi-cycle MUL state and datapath; otherwise op 4 is illegal.
module alu4_seq
`ifdef ALU4_SEQ_MUL_EN
#(
    parameter int MUL_ITERS = 4
)
`endif
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [2:0] cmd_op,
    input  logic [3:0] cmd_a,
    input  logic [3:0] cmd_b,
    output logic [1:0] alu_ctl,
    output logic [3:0] alu_a,
    output logic [3:0] alu_b,
    input  logic [3:0] alu_out,
    input  logic       alu_zf,
    input  logic       alu_cf,
    input  logic       alu_sf,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_data,
    output logic       rsp_zf,
    output logic       rsp_cf,
    output logic       rsp_sf,
    output logic       rsp_err
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
`ifdef ALU4_SEQ_MUL_EN
        , MUL = 2'd3
`endif
    } state_t;

    state_t state;
    logic   err_q;

    assign cmd_ready = (state == IDLE);

`ifdef ALU4_SEQ_MUL_EN
    logic [3:0] p_hi;
    logic [3:0] q;
    logic [1:0] iter;
    logic [3:0] sum;
    logic       carry;
    logic [3:0] nxt_p;
    logic [3:0] nxt_q;

    // one shift-add step: alu4 adds the multiplicand to P_hi; the unsigned carry is recovered by wrap-around compare
    always_comb begin
        sum   = q[0] ? alu_out : p_hi;
        carry = q[0] & (alu_out < alu_a);
        nxt_p = {carry, sum[3:1]};
        nxt_q = {sum[0], q[3:1]};
    end
`endif

    // command sequencing, alu4 drive registers and registered response
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            err_q     <= 1'b0;
            alu_ctl   <= 2'd0;
            alu_a     <= 4'd0;
            alu_b     <= 4'd0;
            rsp_valid <= 1'b0;
            rsp_data  <= 8'h00;
            rsp_zf    <= 1'b0;
            rsp_cf    <= 1'b0;
            rsp_sf    <= 1'b0;
            rsp_err   <= 1'b0;
`ifdef ALU4_SEQ_MUL_EN
            p_hi      <= 4'd0;
            q         <= 4'd0;
            iter      <= 2'd0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        if (!cmd_op[2]) begin
                            state   <= EXEC;
                            err_q   <= 1'b0;
                            alu_ctl <= cmd_op[1:0];
                            alu_a   <= cmd_a;
                            alu_b   <= cmd_b;
                        end
`ifdef ALU4_SEQ_MUL_EN
                        else if (cmd_op == 3'd4) begin
                            state   <= MUL;
                            alu_ctl <= 2'd2;
                            alu_a   <= 4'd0;
                            alu_b   <= cmd_a;
                            p_hi    <= 4'd0;
                            q       <= cmd_b;
                            iter    <= 2'd0;
                        end
`endif
                        else begin
                            // illegal ops take the same one-cycle path, answered with the error response
                            state <= EXEC;
                            err_q <= 1'b1;
                        end
                    end
                end
                EXEC: begin
                    state     <= RESP;
                    rsp_valid <= 1'b1;
                    rsp_data  <= err_q ? 8'h00 : {4'h0, alu_out};
                    rsp_zf    <= err_q | alu_zf;
                    rsp_cf    <= ~err_q & alu_cf;
                    rsp_sf    <= ~err_q & alu_sf;
                    rsp_err   <= err_q;
                    alu_ctl   <= 2'd0;
                    alu_a     <= 4'd0;
                    alu_b     <= 4'd0;
                end
`ifdef ALU4_SEQ_MUL_EN
                MUL: begin
                    p_hi  <= nxt_p;
                    q     <= nxt_q;
                    alu_a <= nxt_p;
                    iter  <= iter + 2'd1;
                    if (iter == 2'(MUL_ITERS - 1)) begin
                        state     <= RESP;
                        rsp_valid <= 1'b1;
                        rsp_data  <= {nxt_p, nxt_q};
                        rsp_zf    <= ({nxt_p, nxt_q} == 8'h00);
                        rsp_cf    <= 1'b0;
                        rsp_sf    <= nxt_p[3];
                        rsp_err   <= 1'b0;
                        alu_ctl   <= 2'd0;
                        alu_a     <= 4'd0;
                        alu_b     <= 4'd0;
                    end
                end
`endif
                RESP: begin
                    if (rsp_ready) begin
                        state     <= IDLE;
                        rsp_valid <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu4_seq.sv
// tb_alu4_seq: table-driven scoreboard bench for alu4_seq with a behavioural alu4 attached
module tb_alu4_seq;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [2:0] cmd_op = 3'd0;
    logic [3:0] cmd_a = 4'd0;
    logic [3:0] cmd_b = 4'd0;
    logic [1:0] alu_ctl;
    logic [3:0] alu_a;
    logic [3:0] alu_b;
    logic [3:0] alu_out;
    logic       alu_zf;
    logic       alu_cf;
    logic       alu_sf;
    logic       rsp_valid;
    logic       rsp_ready = 1'b0;
    logic [7:0] rsp_data;
    logic       rsp_zf;
    logic       rsp_cf;
    logic       rsp_sf;
    logic       rsp_err;
    logic [4:0] s;

    int checks = 0;
    int fails = 0;

    typedef struct {
        logic [2:0] op;
        logic [3:0] a;
        logic [3:0] b;
        logic [7:0] data;
        logic       zf;
        logic       cf;
        logic       sf;
        logic       err;
        int         lat;
    } vec_t;

    typedef struct {
        logic [7:0] data;
        logic       zf;
        logic       cf;
        logic       sf;
        logic       err;
        int         lat;
    } exp_t;

    exp_t sb[$];
    vec_t vt[14];

    always #5 clk = ~clk;

    alu4_seq dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b),
        .alu_ctl(alu_ctl), .alu_a(alu_a), .alu_b(alu_b),
        .alu_out(alu_out), .alu_zf(alu_zf), .alu_cf(alu_cf), .alu_sf(alu_sf),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_zf(rsp_zf), .rsp_cf(rsp_cf), .rsp_sf(rsp_sf), .rsp_err(rsp_err)
    );

    // behavioural alu4: AND/OR/ADD/SUB, CF is signed overflow
    always_comb begin
        case (alu_ctl)
            2'd0:    s = {1'b0, alu_a & alu_b};
            2'd1:    s = {1'b0, alu_a | alu_b};
            2'd2:    s = {1'b0, alu_a} + {1'b0, alu_b};
            default: s = {1'b0, alu_a} - {1'b0, alu_b};
        endcase
        alu_out = s[3:0];
        alu_zf  = (s[3:0] == 4'd0);
        alu_sf  = s[3];
        alu_cf  = (alu_ctl == 2'd2) ? (alu_a[3] == alu_b[3]) && (s[3] != alu_a[3]) :
                  (alu_ctl == 2'd3) ? (alu_a[3] != alu_b[3]) && (s[3] != alu_a[3]) : 1'b0;
    end

    function automatic vec_t mk(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b,
                                input logic [7:0] data, input logic zf, input logic cf,
                                input logic sf, input logic err, input int lat);
        vec_t v;
        v.op = op; v.a = a; v.b = b; v.data = data;
        v.zf = zf; v.cf = cf; v.sf = sf; v.err = err; v.lat = lat;
        return v;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic send(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
        int w = 0;
        @(negedge clk);
        while (!cmd_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        chk("cmd_ready", int'(cmd_ready), 1);
        cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_op = 3'($urandom); cmd_a = 4'($urandom); cmd_b = 4'($urandom);
    endtask

    task automatic get(input string nm);
        exp_t e;
        int lat = 0;
        @(negedge clk);
        while (!rsp_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        if (sb.size() == 0) begin
            checks++;
            fails++;
            $display("FAIL %s scoreboard: response with no expected entry, data %0h", nm, rsp_data);
        end else begin
            e = sb.pop_front();
            chk({nm, " latency"}, lat, e.lat);
            chk({nm, " data"}, int'(rsp_data), int'(e.data));
            chk({nm, " zf"}, int'(rsp_zf), int'(e.zf));
            chk({nm, " cf"}, int'(rsp_cf), int'(e.cf));
            chk({nm, " sf"}, int'(rsp_sf), int'(e.sf));
            chk({nm, " err"}, int'(rsp_err), int'(e.err));
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        chk({nm, " valid_drop"}, int'(rsp_valid), 0);
    endtask

    task automatic push(input vec_t v);
        exp_t e;
        e.data = v.data; e.zf = v.zf; e.cf = v.cf; e.sf = v.sf; e.err = v.err; e.lat = v.lat;
        sb.push_back(e);
    endtask

    initial begin
        vt[0]  = mk(3'd2, 4'd3,  4'd4,  8'h07, 0, 0, 0, 0, 1);
        vt[1]  = mk(3'd2, 4'd7,  4'd1,  8'h08, 0, 1, 1, 0, 1);
        vt[2]  = mk(3'd3, 4'd2,  4'd5,  8'h0D, 0, 0, 1, 0, 1);
        vt[3]  = mk(3'd3, 4'd5,  4'd5,  8'h00, 1, 0, 0, 0, 1);
        vt[4]  = mk(3'd0, 4'hC,  4'hA,  8'h08, 0, 0, 1, 0, 1);
        vt[5]  = mk(3'd1, 4'd5,  4'd2,  8'h07, 0, 0, 0, 0, 1);
        vt[6]  = mk(3'd2, 4'hF,  4'd1,  8'h00, 1, 0, 0, 0, 1);
        vt[7]  = mk(3'd3, 4'd8,  4'd1,  8'h07, 0, 1, 0, 0, 1);
        vt[8]  = mk(3'd6, 4'd3,  4'd3,  8'h00, 1, 0, 0, 1, 1);
        vt[9]  = mk(3'd7, 4'hF,  4'hF,  8'h00, 1, 0, 0, 1, 1);
`ifdef ALU4_SEQ_MUL_EN
        vt[10] = mk(3'd4, 4'hF,  4'hF,  8'hE1, 0, 0, 1, 0, 4);
        vt[11] = mk(3'd4, 4'd0,  4'd9,  8'h00, 1, 0, 0, 0, 4);
        vt[12] = mk(3'd4, 4'd3,  4'd5,  8'h0F, 0, 0, 0, 0, 4);
        vt[13] = mk(3'd4, 4'd13, 4'd11, 8'h8F, 0, 0, 1, 0, 4);
`else
        vt[10] = mk(3'd4, 4'hF,  4'hF,  8'h00, 1, 0, 0, 1, 1);
        vt[11] = mk(3'd4, 4'd0,  4'd9,  8'h00, 1, 0, 0, 1, 1);
        vt[12] = mk(3'd4, 4'd3,  4'd5,  8'h00, 1, 0, 0, 1, 1);
        vt[13] = mk(3'd4, 4'd13, 4'd11, 8'h00, 1, 0, 0, 1, 1);
`endif
        #12;
        chk("reset cmd_ready", int'(cmd_ready), 1);
        chk("reset rsp_valid", int'(rsp_valid), 0);
        chk("reset rsp_data", int'(rsp_data), 0);
        chk("reset flags", int'({rsp_zf, rsp_cf, rsp_sf, rsp_err}), 0);
        chk("reset alu regs", int'({alu_ctl, alu_a, alu_b}), 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 14; i++) begin
            send(vt[i].op, vt[i].a, vt[i].b);
            push(vt[i]);
            get($sformatf("vec%0d", i));
        end

        // backpressure: response must hold while the consumer stalls
        send(3'd2, 4'd3, 4'd4);
        push(mk(3'd2, 4'd3, 4'd4, 8'h07, 0, 0, 0, 0, 1));
        @(negedge clk);
        @(negedge clk);
        for (int c = 0; c < 3; c++) begin
            chk("bp rsp_valid", int'(rsp_valid), 1);
            chk("bp rsp_data", int'(rsp_data), 8'h07);
            chk("bp flags", int'({rsp_zf, rsp_cf, rsp_sf, rsp_err}), 0);
            chk("bp cmd_ready", int'(cmd_ready), 0);
            chk("bp alu regs", int'({alu_ctl, alu_a, alu_b}), 0);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        chk("bp release rsp_valid", int'(rsp_valid), 0);
        chk("bp release cmd_ready", int'(cmd_ready), 1);
        void'(sb.pop_front());

        // reset in the middle of a multiply abandons it
        send(3'd4, 4'hF, 4'hF);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midreset rsp_valid", int'(rsp_valid), 0);
        chk("midreset cmd_ready", int'(cmd_ready), 1);
        chk("midreset alu regs", int'({alu_ctl, alu_a, alu_b}), 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk("midreset no response", int'(rsp_valid), 0);
        end
        chk("scoreboard empty", sb.size(), 0);
        send(3'd2, 4'd1, 4'd1);
        push(mk(3'd2, 4'd1, 4'd1, 8'h02, 0, 0, 0, 0, 1));
        get("post-reset add");

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
